mux_arb_sel: RTL and testbench

- Parametrised, registered N-channel word selector with two modes.
- Direct mode: an explicit selector picks the channel, as the 8-way byte mux does.
- Round-robin mode: the block arbitrates among requesting channels, with an optional lock that holds a grant.
- Sits between register-file/ALU result sources and the shared result bus of the LEG datapath. The output is driven zero when nothing is granted, so several instances can be OR-combined onto one bus.

---
 rtl/mux_arb_pkg.sv | 25 ++
 rtl/mux_arb_sel_rr_pick.sv | 34 +++
 rtl/mux_arb_sel.sv | 121 ++++++++++++
 tb/tb_mux_arb_sel.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the registered channel selector / round-robin arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Modulo-channels increment used to walk the rotating search order.
  function automatic int unsigned next_idx(input int unsigned ptr, input int unsigned channels);
    return (ptr + 1 >= channels) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/mux_arb_sel_rr_pick.sv
// Combinational rotating priority encoder: first requester after rr_ptr, wrapping.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int IDX_W    = 8
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]    rr_ptr,
  output logic                found,
  output logic [IDX_W-1:0]    idx
);

  localparam int EXT = 1 << IDX_W;

  logic [EXT-1:0]   req_ext;
  logic [IDX_W-1:0] cand;

  assign req_ext = EXT'(req);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = rr_ptr;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = IDX_W'(next_idx(32'(cand), CHANNELS));
      if (!found && req_ext[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_arb_sel.sv
// Registered N-channel word selector: direct index select or round-robin arbitration
// with grant lock. Output is zero whenever nothing is granted so instances can be OR-ed.
module mux_arb_sel
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int IDX_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       req,
  input  logic                      mode,
  input  logic [IDX_W-1:0]          sel,
  // "disable" is a reserved word, so the grant-suppress input is named dis.
  input  logic                      dis,
  input  logic                      lock,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic [CHANNELS-1:0]       grant,
  output logic [IDX_W-1:0]          grant_idx,
  output logic [1:0]                state_dbg,
  output logic [IDX_W-1:0]          rr_ptr_dbg
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;

  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic                holder_req;
  logic                gnt_v;
  logic [IDX_W-1:0]    gnt_idx;

  rr_pick #(
    .CHANNELS (CHANNELS),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // In LOCKED the registered one-hot grant identifies the holder.
  assign holder_req = |(req & grant_q);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_v    = 1'b0;
    gnt_idx  = '0;

    if (dis) begin
      state_d = ST_IDLE;
    end else if (mode == MODE_DIRECT) begin
      if (32'(sel) < 32'(CHANNELS)) begin
        gnt_v   = 1'b1;
        gnt_idx = sel;
        state_d = ST_ACTIVE;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      if (state_q == ST_LOCKED && holder_req && lock) begin
        gnt_v   = 1'b1;
        gnt_idx = grant_idx_q;
        state_d = ST_LOCKED;
      end else if (pick_found) begin
        gnt_v    = 1'b1;
        gnt_idx  = pick_idx;
        rr_ptr_d = pick_idx;
        state_d  = lock ? ST_LOCKED : ST_ACTIVE;
      end else begin
        state_d = ST_IDLE;
      end
    end

    out_valid_d = gnt_v;
    grant_idx_d = gnt_v ? gnt_idx : '0;
    out_d       = '0;
    grant_d     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (gnt_v && gnt_idx == IDX_W'(c)) begin
        out_d      = data_in[c*WIDTH +: WIDTH];
        grant_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= IDX_W'(CHANNELS - 1);
      out_q       <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign grant      = grant_q;
  assign grant_idx  = grant_idx_q;
  assign state_dbg  = state_q;
  assign rr_ptr_dbg = rr_ptr_q;

endmodule

// File: tb/tb_mux_arb_sel.sv
// Directed bench for mux_arb_sel (8 channels x 8 bits): direct select, rotation, lock, disable, reset.
module tb_mux_arb_sel;
  import mux_arb_pkg::*;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 8;
  localparam int IDX_W    = 8;

  logic                      clk;
  logic                      rst;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [CHANNELS-1:0]       req;
  logic                      mode;
  logic [IDX_W-1:0]          sel;
  logic                      dis;
  logic                      lock;
  logic [WIDTH-1:0]          out;
  logic                      out_valid;
  logic [CHANNELS-1:0]       grant;
  logic [IDX_W-1:0]          grant_idx;
  logic [1:0]                state_dbg;
  logic [IDX_W-1:0]          rr_ptr_dbg;

  logic [WIDTH-1:0] chan [CHANNELS];

  int checks = 0;
  int errors = 0;

  mux_arb_sel #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .IDX_W    (IDX_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .req        (req),
    .mode       (mode),
    .sel        (sel),
    .dis        (dis),
    .lock       (lock),
    .out        (out),
    .out_valid  (out_valid),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .state_dbg  (state_dbg),
    .rr_ptr_dbg (rr_ptr_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    data_in = '0;
    for (int i = 0; i < CHANNELS; i++) data_in[i*WIDTH +: WIDTH] = chan[i];
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic exp_v, input int exp_idx);
    logic [WIDTH-1:0]    e_out;
    logic [CHANNELS-1:0] e_grant;
    logic [IDX_W-1:0]    e_idx;
    e_out   = exp_v ? chan[exp_idx] : '0;
    e_grant = exp_v ? CHANNELS'(1 << exp_idx) : '0;
    e_idx   = exp_v ? IDX_W'(exp_idx) : '0;
    chk({tag, ".valid"}, 32'(out_valid), 32'(exp_v));
    chk({tag, ".out"},   32'(out),       32'(e_out));
    chk({tag, ".grant"}, 32'(grant),     32'(e_grant));
    chk({tag, ".idx"},   32'(grant_idx), 32'(e_idx));
  endtask

  task automatic check_st(input string tag, input state_e exp_st, input int exp_ptr);
    chk({tag, ".state"},  32'(state_dbg),  32'(exp_st));
    chk({tag, ".rr_ptr"}, 32'(rr_ptr_dbg), 32'(exp_ptr));
  endtask

  initial begin
    chan[0] = 8'hD0; chan[1] = 8'hC1; chan[2] = 8'hB2; chan[3] = 8'hA5;
    chan[4] = 8'hC4; chan[5] = 8'hD5; chan[6] = 8'hE6; chan[7] = 8'hF7;
    rst = 1'b1; req = '0; mode = MODE_DIRECT; sel = '0; dis = 1'b0; lock = 1'b0;

    // reset state
    step();
    check_out("reset", 1'b0, 0);
    check_st("reset", ST_IDLE, 7);
    rst = 1'b0;

    // direct mode: in-range, boundary, out-of-range
    sel = 8'd3;
    step();
    check_out("dir_sel3", 1'b1, 3);
    check_st("dir_sel3", ST_ACTIVE, 7);
    sel = 8'd7;
    step();
    check_out("dir_sel7", 1'b1, 7);
    sel = 8'd8;
    step();
    check_out("dir_sel8", 1'b0, 0);
    sel = 8'd9;
    step();
    check_out("dir_sel9", 1'b0, 0);
    check_st("dir_sel9", ST_IDLE, 7);

    // full rotation with wrap after reset
    rst = 1'b1;
    step();
    rst = 1'b0; mode = MODE_RR; req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      check_out($sformatf("rot%0d", i), 1'b1, i % 8);
    end
    check_st("rot_end", ST_ACTIVE, 0);

    // sparse requests: park pointer at 5, then alternate 2,5,2
    req = 8'h20;
    step();
    check_out("sp_park5", 1'b1, 5);
    req = 8'h24;
    step();
    check_out("sp_a", 1'b1, 2);
    step();
    check_out("sp_b", 1'b1, 5);
    step();
    check_out("sp_c", 1'b1, 2);
    req = 8'h00;
    step();
    check_out("sp_none", 1'b0, 0);
    check_st("sp_none", ST_IDLE, 2);

    // lock: hold ch0 for four cycles, with ch0 data changing while held
    rst = 1'b1;
    step();
    rst = 1'b0; req = 8'h0F; lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chan[0] = 8'h3C;
      step();
      check_out($sformatf("lk_hold%0d", i), 1'b1, 0);
      check_st($sformatf("lk_hold%0d", i), ST_LOCKED, 0);
    end
    req = 8'h0E;
    step();
    check_out("lk_drop0", 1'b1, 1);
    check_st("lk_drop0", ST_LOCKED, 1);
    step();
    check_out("lk_hold1", 1'b1, 1);
    check_st("lk_hold1", ST_LOCKED, 1);
    lock = 1'b0;
    step();
    check_out("lk_release", 1'b1, 2);
    check_st("lk_release", ST_ACTIVE, 2);

    // disable while locked on ch1
    lock = 1'b1; req = 8'h02;
    step();
    check_out("dis_setup", 1'b1, 1);
    check_st("dis_setup", ST_LOCKED, 1);
    dis = 1'b1;
    step();
    check_out("dis_on", 1'b0, 0);
    check_st("dis_on", ST_IDLE, 1);
    dis = 1'b0; lock = 1'b0;
    step();
    check_out("dis_off", 1'b1, 1);
    check_st("dis_off", ST_ACTIVE, 1);

    // switching to direct mode while locked drops the lock
    lock = 1'b1;
    step();
    check_st("mode_setup", ST_LOCKED, 1);
    mode = MODE_DIRECT; sel = 8'd4;
    step();
    check_out("mode_dir", 1'b1, 4);
    check_st("mode_dir", ST_ACTIVE, 1);
    mode = MODE_RR; lock = 1'b0; req = 8'hFF;
    step();
    check_out("mode_rr", 1'b1, 2);

    // reset mid-rotation
    step();
    check_out("mid_rot", 1'b1, 3);
    rst = 1'b1;
    step();
    check_out("rst_mid", 1'b0, 0);
    check_st("rst_mid", ST_IDLE, 7);
    rst = 1'b0;
    step();
    check_out("rst_first", 1'b1, 0);
    check_st("rst_first", ST_ACTIVE, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
